// File: rtl/alu_sched.sv
// alu_sched: two-requester round-robin scheduler in front of a shared external
// 8-bit ALU. One command is in flight at a time. Direct ops use the ALU for a
// single cycle. MUL (when enabled) is built from repeated ALU additions.
// Reserved commands return an error response without touching the ALU.
module alu_sched #(
    parameter bit MUL_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_cmd,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_cmd,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_y,
    output logic       rsp_zero,
    output logic       rsp_ovf,
    output logic       rsp_err,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [7:0] alu_y,
    input  logic       alu_zero
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MUL,
        S_RESP
    } state_t;

    state_t     state;
    state_t     state_nx;

    logic       last_id;
    logic [2:0] op_r;
    logic [7:0] a_r;
    logic [7:0] b_r;
    logic       id_r;
    logic [7:0] acc;
    logic [7:0] cnt;
    logic       ovf;

    logic       any_valid;
    logic       grant_id;
    logic [3:0] sel_cmd;
    logic [7:0] sel_a;
    logic [7:0] sel_b;
    logic       sel_direct;
    logic       sel_mul;
    logic       accept;

    // Round-robin grant and selection of the granted request's fields
    always_comb begin
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_id;
        end else begin
            grant_id = req1_valid;
        end
        sel_cmd    = grant_id ? req1_cmd : req0_cmd;
        sel_a      = grant_id ? req1_a   : req0_a;
        sel_b      = grant_id ? req1_b   : req0_b;
        sel_direct = ~sel_cmd[3];
        sel_mul    = (sel_cmd == 4'b1000) && MUL_EN;
        accept     = (state == S_IDLE) && any_valid;
    end

    // Next-state logic plus ready, response-valid and ALU drive outputs
    always_comb begin
        state_nx   = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        alu_a      = '0;
        alu_b      = '0;
        alu_op     = 3'b000;
        case (state)
            S_IDLE: begin
                if (any_valid) begin
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    if (sel_direct) begin
                        state_nx = S_EXEC;
                    end else if (sel_mul) begin
                        state_nx = S_MUL;
                    end else begin
                        state_nx = S_RESP;
                    end
                end
            end
            S_EXEC: begin
                alu_a    = a_r;
                alu_b    = b_r;
                alu_op   = op_r;
                state_nx = S_RESP;
            end
            S_MUL: begin
                if (cnt != 8'd0) begin
                    alu_a  = acc;
                    alu_b  = a_r;
                    alu_op = 3'b010;
                end else begin
                    state_nx = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Command capture, multiply accumulator and response registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_id  <= 1'b1;
            op_r     <= '0;
            a_r      <= '0;
            b_r      <= '0;
            id_r     <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            rsp_id   <= 1'b0;
            rsp_y    <= '0;
            rsp_zero <= 1'b0;
            rsp_ovf  <= 1'b0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        last_id <= grant_id;
                        op_r    <= sel_cmd[2:0];
                        a_r     <= sel_a;
                        b_r     <= sel_b;
                        id_r    <= grant_id;
                        if (sel_mul) begin
                            acc <= '0;
                            cnt <= sel_b;
                            ovf <= 1'b0;
                        end else if (!sel_direct) begin
                            // Reserved command: the error response is ready at once
                            rsp_id   <= grant_id;
                            rsp_y    <= '0;
                            rsp_zero <= 1'b1;
                            rsp_ovf  <= 1'b0;
                            rsp_err  <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    rsp_id   <= id_r;
                    rsp_y    <= alu_y;
                    rsp_zero <= alu_zero;
                    rsp_ovf  <= 1'b0;
                    rsp_err  <= 1'b0;
                end
                S_MUL: begin
                    if (cnt != 8'd0) begin
                        acc <= alu_y;
                        cnt <= cnt - 8'd1;
                        // A wrapped sum is smaller than the running total
                        ovf <= ovf | (alu_y < acc);
                    end else begin
                        rsp_id   <= id_r;
                        rsp_y    <= acc;
                        rsp_zero <= (acc == 8'h00);
                        rsp_ovf  <= ovf;
                        rsp_err  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: directed vectors with literal expectations
// plus a transaction-level model checked against the DUT every cycle.
module tb_alu_sched;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_cmd = '0, req1_cmd = '0;
    logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic       rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_zero, rsp_ovf, rsp_err;
    logic [7:0] rsp_y, alu_a, alu_b, alu_y;
    logic [2:0] alu_op;
    logic       alu_zero;

    // second instance with MUL disabled
    logic       u_req0_valid = 1'b0;
    logic       u_req0_ready, u_req1_ready;
    logic [3:0] u_req0_cmd = '0;
    logic [7:0] u_req0_a = '0, u_req0_b = '0;
    logic       u_rsp_valid, u_rsp_id, u_rsp_zero, u_rsp_ovf, u_rsp_err;
    logic [7:0] u_rsp_y, u_alu_a, u_alu_b, u_alu_y;
    logic [2:0] u_alu_op;
    logic       u_alu_zero;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_calc(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0: return a;
            3'd1: return ~a;
            3'd2: return a + b;
            3'd3: return a - b;
            3'd4: return a & b;
            3'd5: return a | b;
            3'd6: return 8'h00 - a;
            default: return 8'h00 - b;
        endcase
    endfunction

    assign alu_y      = alu_calc(alu_op, alu_a, alu_b);
    assign alu_zero   = (alu_y == 8'h00);
    assign u_alu_y    = alu_calc(u_alu_op, u_alu_a, u_alu_b);
    assign u_alu_zero = (u_alu_y == 8'h00);

    alu_sched dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cmd(req0_cmd), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cmd(req1_cmd), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
        .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y), .alu_zero(alu_zero)
    );

    alu_sched #(.MUL_EN(1'b0)) dut_nomul (
        .clk(clk), .reset(reset),
        .req0_valid(u_req0_valid), .req0_ready(u_req0_ready), .req0_cmd(u_req0_cmd), .req0_a(u_req0_a), .req0_b(u_req0_b),
        .req1_valid(1'b0), .req1_ready(u_req1_ready), .req1_cmd(4'h0), .req1_a(8'h00), .req1_b(8'h00),
        .rsp_valid(u_rsp_valid), .rsp_ready(1'b1), .rsp_id(u_rsp_id), .rsp_y(u_rsp_y),
        .rsp_zero(u_rsp_zero), .rsp_ovf(u_rsp_ovf), .rsp_err(u_rsp_err),
        .alu_a(u_alu_a), .alu_b(u_alu_b), .alu_op(u_alu_op), .alu_y(u_alu_y), .alu_zero(u_alu_zero)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct packed {
        logic [7:0] y;
        logic       zero;
        logic       ovf;
        logic       err;
    } res_t;

    function automatic res_t expect_of(input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b);
        res_t r;
        int   p;
        r = '0;
        if (!cmd[3]) begin
            r.y = alu_calc(cmd[2:0], a, b);
        end else if (cmd == 4'b1000) begin
            p     = int'(a) * int'(b);
            r.y   = p[7:0];
            r.ovf = (p > 255);
        end else begin
            r.err = 1'b1;
        end
        r.zero = (r.y == 8'h00);
        return r;
    endfunction

    int         m_phase = 0;   // 0 waiting for a request, 1 computing, 2 response offered
    int         m_wait  = 0;
    bit         m_last  = 1'b1;
    bit         m_exec  = 1'b0;
    bit         m_id    = 1'b0;
    res_t       m_res   = '0;
    logic [2:0] m_op    = '0;
    logic [7:0] m_a     = '0, m_b = '0;

    logic       g;
    logic [3:0] gc;
    logic [7:0] ga, gb;

    always_comb begin
        g  = (req0_valid && req1_valid) ? !m_last : req1_valid;
        gc = g ? req1_cmd : req0_cmd;
        ga = g ? req1_a : req0_a;
        gb = g ? req1_b : req0_b;
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase <= 0;
            m_last  <= 1'b1;
            m_exec  <= 1'b0;
            m_wait  <= 0;
        end else begin
            case (m_phase)
                0: if (req0_valid || req1_valid) begin
                    m_last <= g;
                    m_id   <= g;
                    m_res  <= expect_of(gc, ga, gb);
                    m_op   <= gc[2:0];
                    m_a    <= ga;
                    m_b    <= gb;
                    if (!gc[3]) begin
                        m_phase <= 1; m_wait <= 1; m_exec <= 1'b1;
                    end else if (gc == 4'b1000) begin
                        m_phase <= 1; m_wait <= int'(gb) + 1; m_exec <= 1'b0;
                    end else begin
                        m_phase <= 2; m_exec <= 1'b0;
                    end
                end
                1: begin
                    if (m_wait == 1) m_phase <= 2;
                    m_wait <= m_wait - 1;
                end
                default: if (rsp_ready) m_phase <= 0;
            endcase
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            if (!reset) begin
                check("rst_rsp_valid", rsp_valid, 0);
                check("rst_alu_op", alu_op, 0);
            end else begin
                check("req0_ready", req0_ready, (m_phase == 0) && (req0_valid || req1_valid) && !g);
                check("req1_ready", req1_ready, (m_phase == 0) && (req0_valid || req1_valid) && g);
                check("rsp_valid", rsp_valid, m_phase == 2);
                if (m_phase == 2) begin
                    check("rsp_id", rsp_id, m_id);
                    check("rsp_y", rsp_y, m_res.y);
                    check("rsp_zero", rsp_zero, m_res.zero);
                    check("rsp_ovf", rsp_ovf, m_res.ovf);
                    check("rsp_err", rsp_err, m_res.err);
                end
                if (m_phase == 1 && m_exec) begin
                    check("exec_alu_op", alu_op, m_op);
                    check("exec_alu_a", alu_a, m_a);
                    check("exec_alu_b", alu_b, m_b);
                end else if (m_phase != 1) begin
                    check("idle_alu_a", alu_a, 0);
                    check("idle_alu_b", alu_b, 0);
                    check("idle_alu_op", alu_op, 0);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic send(input bit id, input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b);
        bit took = 1'b0;
        if (id) begin
            req1_valid = 1'b1; req1_cmd = cmd; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_cmd = cmd; req0_a = a; req0_b = b;
        end
        for (int k = 0; k < 50 && !took; k++) begin
            @(negedge clk);
            took = id ? req1_ready : req0_ready;
            @(posedge clk); #1;
        end
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
        if (!took) check("send_timeout", 0, 1);
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rsp_valid) check("rsp_timeout", 0, 1);
    endtask

    task automatic expect_rsp(input string name, input bit id, input logic [7:0] y, input bit zero,
                              input bit ovf, input bit err, input int lat);
        int n;
        wait_rsp(n);
        check({name, "_lat"}, n, lat);
        check({name, "_id"}, rsp_id, id);
        check({name, "_y"}, rsp_y, y);
        check({name, "_zero"}, rsp_zero, zero);
        check({name, "_ovf"}, rsp_ovf, ovf);
        check({name, "_err"}, rsp_err, err);
        @(posedge clk); #1;
    endtask

    typedef struct {
        bit         id;
        logic [3:0] cmd;
        logic [7:0] a, b, y;
    } vec_t;

    vec_t vecs[7] = '{
        '{1'b0, 4'd0, 8'h5A, 8'h00, 8'h5A},
        '{1'b1, 4'd1, 8'h0F, 8'h00, 8'hF0},
        '{1'b0, 4'd3, 8'h00, 8'h01, 8'hFF},
        '{1'b1, 4'd5, 8'h0C, 8'h30, 8'h3C},
        '{1'b0, 4'd6, 8'h01, 8'h00, 8'hFF},
        '{1'b1, 4'd7, 8'h00, 8'h00, 8'h00},
        '{1'b0, 4'd2, 8'hFF, 8'h01, 8'h00}
    };

    initial begin
        bit seen;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_y", rsp_y, 0);
        check("reset_rsp_zero", rsp_zero, 0);
        check("reset_rsp_ovf", rsp_ovf, 0);
        check("reset_rsp_err", rsp_err, 0);
        check("reset_rsp_id", rsp_id, 0);
        check("reset_alu", {alu_a, alu_b, alu_op}, 0);
        check("reset_ready", {req0_ready, req1_ready}, 0);
        reset  = 1'b1;
        chk_en = 1'b1;

        // add with carry into bit 7
        send(0, 4'b0010, 8'h7F, 8'h01);
        expect_rsp("add7f", 0, 8'h80, 0, 0, 0, 1);

        // direct op table
        foreach (vecs[i]) begin
            send(vecs[i].id, vecs[i].cmd, vecs[i].a, vecs[i].b);
            expect_rsp("direct", vecs[i].id, vecs[i].y, vecs[i].y == 8'h00, 0, 0, 1);
        end

        // multiply
        send(0, 4'b1000, 8'd20, 8'd13);
        expect_rsp("mul20x13", 0, 8'h04, 0, 1, 0, 14);
        send(1, 4'b1000, 8'd7, 8'd0);
        expect_rsp("mul7x0", 1, 8'h00, 1, 0, 0, 1);
        send(0, 4'b1000, 8'd15, 8'd17);
        expect_rsp("mul15x17", 0, 8'hFF, 0, 0, 0, 18);

        // reserved command
        send(1, 4'b1011, 8'h12, 8'h34);
        expect_rsp("reserved", 1, 8'h00, 1, 0, 1, 0);

        // MUL treated as reserved when disabled
        u_req0_valid = 1'b1; u_req0_cmd = 4'b1000; u_req0_a = 8'd5; u_req0_b = 8'd5;
        @(negedge clk);
        check("nomul_ready", u_req0_ready, 1);
        @(posedge clk); #1;
        u_req0_valid = 1'b0;
        check("nomul_valid", u_rsp_valid, 1);
        check("nomul_err", u_rsp_err, 1);
        check("nomul_y", u_rsp_y, 0);
        check("nomul_zero", u_rsp_zero, 1);
        check("nomul_ovf", u_rsp_ovf, 0);
        @(posedge clk); #1;
        check("nomul_done", u_rsp_valid, 0);

        // round-robin alternation from a fresh reset
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        req0_valid = 1'b1; req0_cmd = 4'b0011; req0_a = 8'd5;    req0_b = 8'd5;
        req1_valid = 1'b1; req1_cmd = 4'b0100; req1_a = 8'hF0;   req1_b = 8'h0F;
        expect_rsp("rr_first", 0, 8'h00, 1, 0, 0, 2);
        expect_rsp("rr_second", 1, 8'h00, 1, 0, 0, 2);
        expect_rsp("rr_third", 0, 8'h00, 1, 0, 0, 2);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // response backpressure
        rsp_ready = 1'b0;
        send(0, 4'b0010, 8'd3, 8'd4);
        begin
            int n;
            wait_rsp(n);
        end
        req1_valid = 1'b1; req1_cmd = 4'b0101; req1_a = 8'h0C; req1_b = 8'h30;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("hold_valid", rsp_valid, 1);
            check("hold_y", rsp_y, 8'h07);
            check("hold_id", rsp_id, 0);
            check("hold_zero", rsp_zero, 0);
            check("hold_req1_ready", req1_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("release_valid", rsp_valid, 0);
        check("release_req1_ready", req1_ready, 1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        expect_rsp("after_hold", 1, 8'h3C, 0, 0, 0, 1);

        // reset in the middle of a long multiply
        send(0, 4'b1000, 8'd3, 8'd200);
        repeat (5) @(posedge clk);
        #1;
        check("mid_mul_op", alu_op, 3'b010);
        reset = 1'b0;
        #1;
        check("mr_rsp_valid", rsp_valid, 0);
        check("mr_rsp_y", rsp_y, 0);
        check("mr_rsp_id", rsp_id, 0);
        check("mr_rsp_flags", {rsp_zero, rsp_ovf, rsp_err}, 0);
        check("mr_alu", {alu_a, alu_b, alu_op}, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 230; c++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        check("no_rsp_after_reset", seen, 0);
        send(1, 4'b0100, 8'hF0, 8'h3C);
        expect_rsp("post_reset", 1, 8'h30, 0, 0, 0, 1);

        repeat (2) @(posedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 Parameter MUL_EN, default 1, enables extended command MUL (cmd 4'b1000); when 0, MUL is treated as reserved.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low (0 = reset asserted).
REQ-004 req0_valid / req1_valid  input  1 each  requester N presents a command.
REQ-005 req0_ready / req1_ready  output  1 each  command accepted on a cycle where valid and ready are both 1.
REQ-006 req0_cmd / req1_cmd  input  4 each  cmd[3]=0: direct ALU op cmd[2:0]; 4'b1000: MUL; 4'b1001-4'b1111: reserved.
REQ-007 req0_a, req0_b, req1_a, req1_b  input  8 each  operands.
REQ-008 rsp_valid  output  1  response available.
REQ-009 rsp_ready  input  1  consumer accepts the response.
REQ-010 rsp_id  output  1  requester index (0/1) of the response.
REQ-011 rsp_y  output  8  result.
REQ-012 rsp_zero  output  1  1 when rsp_y == 8'h00.
REQ-013 rsp_ovf  output  1  MUL unsigned overflow (true product > 255); 0 for all other commands.
REQ-014 rsp_err  output  1  reserved command; rsp_y = 8'h00 and rsp_zero = 1 when set.
REQ-015 alu_a, alu_b  output  8 each  operands driven to the shared 8-bit ALU.
REQ-016 alu_op  output  3  ALU op select (000 pass a, 001 not a, 010 add, 011 sub, 100 and, 101 or, 110 -a, 111 -b).
REQ-017 alu_y  input  8; alu_zero  input  1  combinational ALU result and zero flag.

Function
REQ-018 FSM states: IDLE, EXEC, MUL, RESP; one command in flight at a time.
REQ-019 IDLE: if any reqN_valid, grant exactly one; only the granted reqN_ready is 1 (combinational, IDLE only); every reqN_ready is 0 in all other states.
REQ-020 Arbitration: round-robin on pointer last_id; both valid -> grant the index != last_id; one valid -> grant it; last_id updates to the granted index on acceptance.
REQ-021 On acceptance, capture cmd, a, b and id into internal registers; later changes on the request inputs have no effect.
REQ-022 Next state from IDLE: direct op -> EXEC; MUL with MUL_EN=1 -> MUL (acc <= 0, cnt <= b, ovf <= 0); reserved -> RESP with rsp_err = 1.
REQ-023 EXEC (one cycle): alu_a = a_r, alu_b = b_r, alu_op = cmd_r[2:0]; latch alu_y into rsp_y and alu_zero into rsp_zero; go to RESP.
REQ-024 MUL, cnt != 0: alu_op = 010, alu_a = acc, alu_b = a_r; acc <= alu_y; cnt <= cnt-1; ovf <= ovf | (alu_y < acc).
REQ-025 MUL, cnt == 0: rsp_y <= acc, rsp_zero <= (acc == 0), rsp_ovf <= ovf; go to RESP. MUL occupies b+1 cycles.
REQ-026 Outside EXEC/MUL: alu_a = 0, alu_b = 0, alu_op = 000.
REQ-027 RESP: rsp_valid = 1; rsp_id/y/zero/ovf/err held stable until rsp_ready = 1; on that edge go to IDLE.
REQ-028 Latency: direct op accepted at edge N -> rsp_valid from edge N+1 (EXEC then RESP); minimum issue interval 3 cycles.
REQ-029 rsp_valid never falls without rsp_ready; requests arriving during EXEC/MUL/RESP wait with ready = 0.
REQ-030 Results wrap modulo 256; no saturation.

Reset
REQ-031 reset = 0 forces immediately: state IDLE, last_id = 1 (req0 wins first contention), acc/cnt/ovf = 0, rsp_valid = 0, rsp_y = 0, rsp_zero = 0, rsp_ovf = 0, rsp_err = 0, rsp_id = 0, alu_a = alu_b = 0, alu_op = 000.
REQ-032 Reset asserted mid-EXEC/MUL/RESP discards the in-flight command; no response is produced for it.

Verification
REQ-033 req0: cmd 0010, a=8'h7F, b=8'h01, rsp_ready=1 -> 2 cycles later rsp_valid=1, rsp_id=0, rsp_y=8'h80, rsp_zero=0.
REQ-034 Both valid continuously: req0 cmd 0011 a=5 b=5, req1 cmd 0100 a=F0 b=0F -> first rsp id0 y=00 zero=1, then id1 y=00 zero=1, then id0 again (alternation).
REQ-035 MUL a=8'd20, b=8'd13 -> rsp after 14 MUL cycles, y=8'h04, ovf=1; MUL a=7, b=0 -> y=0, zero=1, ovf=0, 1 MUL cycle.
REQ-036 cmd 1011 -> rsp_err=1, rsp_y=0, rsp_zero=1; with MUL_EN=0, cmd 1000 also gives rsp_err=1.
REQ-037 Hold rsp_ready=0 for 5 cycles in RESP -> outputs stable, req1_valid=1 sees ready=0 throughout; released -> IDLE, req1 accepted next cycle.
REQ-038 Assert reset during MUL (b=200) -> all outputs at reset values immediately; no response after release; next request served normally.
